// File: rtl/vip_bin_morph_3x3_if.sv
// Binary pixel stream bundle for the 3x3 morphology stage: upstream per_* framing and pixel,
// downstream post_* framing and result. The stage itself connects through the slave modport.
interface vip_bin_morph_3x3_if;
    logic per_frame_vsync;
    logic per_frame_href;
    logic per_frame_clken;
    logic per_img_Bit;
    logic post_frame_vsync;
    logic post_frame_href;
    logic post_frame_clken;
    logic post_img_Bit;

    modport master (
        output per_frame_vsync, per_frame_href, per_frame_clken, per_img_Bit,
        input  post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit
    );

    modport slave (
        input  per_frame_vsync, per_frame_href, per_frame_clken, per_img_Bit,
        output post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit
    );
endinterface

// File: rtl/vip_bin_morph_3x3.sv
// Streaming 3x3 binary erosion/dilation with two line buffers and a fixed 3-clk latency.
// Optional macro VIP_MORPH_BORDER_CLR_EN forces incomplete-window positions (x<2 or y<2) to 0.
module vip_bin_morph_3x3 #(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                morph_mode,
    vip_bin_morph_3x3_if.slave  bus
);
    localparam int XW = $clog2(IMG_HDISP + 1);
    localparam int YW = $clog2(IMG_VDISP + 1);
    localparam int AW = (IMG_HDISP > 1) ? $clog2(IMG_HDISP) : 1;

    logic [XW-1:0] x_cnt;
    logic [YW-1:0] y_cnt;
    logic          href_q;
    logic          mode_q;
    logic [2:0]    vsync_d;
    logic [2:0]    href_d;
    logic [2:0]    clken_d;
    logic          lb1 [IMG_HDISP];
    logic          lb2 [IMG_HDISP];

    logic          href_fall;
    logic          x_in;
    logic [AW-1:0] rd_addr;

    logic [2:0]    col_s1;
    logic          x1_s1, x2_s1, y1_s1, y2_s1, inr_s1;
    logic [2:0]    win_c0, win_c1, win_c2;
    logic          x1_s2, x2_s2, y1_s2, y2_s2, inr_s2;
    logic          post_bit;

    logic [2:0]    row_ok;
    logic [2:0]    col_ok;
    logic [8:0]    win;
    logic [8:0]    tap;
    logic          reduced;
    logic          keep;

    assign href_fall = href_q & ~bus.per_frame_href;
    assign x_in      = (x_cnt < XW'(IMG_HDISP));
    assign rd_addr   = x_in ? x_cnt[AW-1:0] : '0;

    // y_cnt clear during vsync low wins over the href-fall increment
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            href_q <= 1'b0;
            x_cnt  <= '0;
            y_cnt  <= '0;
            mode_q <= 1'b0;
        end else begin
            href_q <= bus.per_frame_href;
            if (href_fall)
                x_cnt <= '0;
            else if (bus.per_frame_clken && x_in)
                x_cnt <= x_cnt + XW'(1);
            if (!bus.per_frame_vsync)
                y_cnt <= '0;
            else if (href_fall && (y_cnt < YW'(IMG_VDISP)))
                y_cnt <= y_cnt + YW'(1);
            if (!bus.per_frame_vsync)
                mode_q <= morph_mode;
        end
    end

    // Read-before-write: lb2 receives the old lb1 entry; stale frames are masked by y_cnt instead of cleared
    always_ff @(posedge clk) begin
        if (bus.per_frame_clken && x_in) begin
            lb1[rd_addr] <= bus.per_img_Bit;
            lb2[rd_addr] <= lb1[rd_addr];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vsync_d <= '0;
            href_d  <= '0;
            clken_d <= '0;
            col_s1  <= '0;
            x1_s1   <= 1'b0;
            x2_s1   <= 1'b0;
            y1_s1   <= 1'b0;
            y2_s1   <= 1'b0;
            inr_s1  <= 1'b0;
            win_c0  <= '0;
            win_c1  <= '0;
            win_c2  <= '0;
            x1_s2   <= 1'b0;
            x2_s2   <= 1'b0;
            y1_s2   <= 1'b0;
            y2_s2   <= 1'b0;
            inr_s2  <= 1'b0;
            post_bit <= 1'b0;
        end else begin
            vsync_d <= {vsync_d[1:0], bus.per_frame_vsync};
            href_d  <= {href_d[1:0],  bus.per_frame_href};
            clken_d <= {clken_d[1:0], bus.per_frame_clken};
            col_s1  <= {lb2[rd_addr], lb1[rd_addr], bus.per_img_Bit};
            x1_s1   <= (x_cnt >= XW'(1));
            x2_s1   <= (x_cnt >= XW'(2));
            y1_s1   <= (y_cnt >= YW'(1));
            y2_s1   <= (y_cnt >= YW'(2));
            inr_s1  <= x_in;
            win_c0  <= col_s1;
            win_c1  <= win_c0;
            win_c2  <= win_c1;
            x1_s2   <= x1_s1;
            x2_s2   <= x2_s1;
            y1_s2   <= y1_s1;
            y2_s2   <= y2_s1;
            inr_s2  <= inr_s1;
            post_bit <= keep & reduced;
        end
    end

    // Window bit c*3+r: column x-c, row y-r; out-of-image taps take the neutral value
    assign row_ok = {y2_s2, y1_s2, 1'b1};
    assign col_ok = {x2_s2, x1_s2, 1'b1};
    assign win    = {win_c2, win_c1, win_c0};

    always_comb begin
        tap = '0;
        for (int c = 0; c < 3; c++) begin
            for (int r = 0; r < 3; r++) begin
                tap[c*3+r] = (col_ok[c] && row_ok[r]) ? win[c*3+r] : ~mode_q;
            end
        end
        reduced = mode_q ? (|tap) : (&tap);
`ifdef VIP_MORPH_BORDER_CLR_EN
        keep = clken_d[1] & inr_s2 & x2_s2 & y2_s2;
`else
        keep = clken_d[1] & inr_s2;
`endif
    end

    assign bus.post_frame_vsync = vsync_d[2];
    assign bus.post_frame_href  = href_d[2];
    assign bus.post_frame_clken = clken_d[2];
    assign bus.post_img_Bit     = post_bit;
endmodule

// File: tb/tb_vip_bin_morph_3x3.sv
// Self-checking bench for vip_bin_morph_3x3: generated frames vs a window-rule reference model.
// Honours VIP_MORPH_BORDER_CLR_EN the same way as the design.
module tb_vip_bin_morph_3x3;
    localparam int HD       = 8;
    localparam int VD       = 6;
    localparam int H_SYNC   = 5;
    localparam int H_BACK   = 5;
    localparam int H_FRONT  = 5;
    localparam int V_SYNC   = 1;
    localparam int V_FRONT  = 1;
    localparam int LINE_CLK = H_SYNC + H_BACK + HD + H_FRONT;

    typedef struct {
        logic v;
        logic h;
        logic c;
        int   x;
        int   y;
        bit   cap;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic morph_mode = 1'b0;

    rec_t hist[$];
    bit   img     [VD][HD];
    logic cap_img [VD][HD];
    bit   got     [VD][HD];
    int   errors = 0;
    int   checks = 0;

    vip_bin_morph_3x3_if bus ();

    vip_bin_morph_3x3 #(.IMG_HDISP(HD), .IMG_VDISP(VD)) dut (
        .clk        (clk),
        .rst        (rst),
        .morph_mode (morph_mode),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic observed, input logic expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic check_count(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic clear_hist();
        rec_t z;
        z.v = 1'b0; z.h = 1'b0; z.c = 1'b0; z.x = 0; z.y = 0; z.cap = 1'b0;
        hist = {};
        hist.push_back(z);
        hist.push_back(z);
    endtask

    // One clock: drive inputs, clock, then compare outputs with the inputs driven three clocks earlier
    task automatic drive_cycle(input logic v, input logic h, input logic b,
                               input int x, input int y, input bit cap);
        rec_t r;
        rec_t e;
        bus.per_frame_vsync = v;
        bus.per_frame_href  = h;
        bus.per_frame_clken = h;
        bus.per_img_Bit     = b;
        r.v = v; r.h = h; r.c = h; r.x = x; r.y = y; r.cap = cap;
        if (!rst) hist.push_back(r);
        @(posedge clk);
        #1;
        if (rst) begin
            e.v = 1'b0; e.h = 1'b0; e.c = 1'b0; e.x = 0; e.y = 0; e.cap = 1'b0;
        end else begin
            e = hist[hist.size()-3];
        end
        checkOutput("post_frame_vsync", bus.post_frame_vsync, e.v);
        checkOutput("post_frame_href",  bus.post_frame_href,  e.h);
        checkOutput("post_frame_clken", bus.post_frame_clken, e.c);
        if (e.c && e.cap) begin
            cap_img[e.y][e.x] = bus.post_img_Bit;
            got[e.y][e.x] = 1'b1;
        end else if (!e.c) begin
            checkOutput("post_img_Bit_idle", bus.post_img_Bit, 1'b0);
        end
        if (hist.size() > 8) void'(hist.pop_front());
    endtask

    // One full frame from img; optional mode switch and mid-frame reset
    task automatic applyStimulus(input logic mode_start, input int switch_line,
                                 input logic mode_after, input int reset_line, input bit cap);
        for (int y = 0; y < VD; y++)
            for (int x = 0; x < HD; x++) begin
                got[y][x] = 1'b0;
                cap_img[y][x] = 1'b0;
            end
        morph_mode = mode_start;
        for (int i = 0; i < V_SYNC * LINE_CLK; i++) drive_cycle(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        for (int y = 0; y < VD; y++) begin
            if (y == switch_line) morph_mode = mode_after;
            for (int i = 0; i < H_SYNC + H_BACK; i++) drive_cycle(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
            for (int x = 0; x < HD; x++) begin
                drive_cycle(1'b1, 1'b1, logic'(img[y][x]), x, y, cap);
                if (y == reset_line && x == 3) begin
                    rst = 1'b1;
                    #1;
                    checkOutput("rst_vsync", bus.post_frame_vsync, 1'b0);
                    checkOutput("rst_href",  bus.post_frame_href,  1'b0);
                    checkOutput("rst_clken", bus.post_frame_clken, 1'b0);
                    checkOutput("rst_bit",   bus.post_img_Bit,     1'b0);
                end
            end
            if (rst) begin
                rst = 1'b0;
                clear_hist();
            end
            for (int i = 0; i < H_FRONT; i++) drive_cycle(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
        end
        for (int i = 0; i < V_FRONT * LINE_CLK; i++) drive_cycle(1'b1, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    // Reference: AND/OR over rows y-2..y, cols x-2..x of the input frame, neutral outside the image
    function automatic logic ref_pixel(input int x, input int y, input bit dil);
        bit acc;
        bit t;
`ifdef VIP_MORPH_BORDER_CLR_EN
        if (x < 2 || y < 2) return 1'b0;
`endif
        acc = !dil;
        for (int dy = 0; dy < 3; dy++)
            for (int dx = 0; dx < 3; dx++) begin
                t = (x - dx < 0 || y - dy < 0) ? !dil : img[y-dy][x-dx];
                acc = dil ? (acc | t) : (acc & t);
            end
        return logic'(acc);
    endfunction

    task automatic check_frame(input string tag, input bit dil, output int ones);
        ones = 0;
        for (int y = 0; y < VD; y++)
            for (int x = 0; x < HD; x++) begin
                checkOutput($sformatf("%s seen(%0d,%0d)", tag, x, y), logic'(got[y][x]), 1'b1);
                checkOutput($sformatf("%s px(%0d,%0d)", tag, x, y), cap_img[y][x], ref_pixel(x, y, dil));
                if (cap_img[y][x] === 1'b1) ones++;
            end
    endtask

    task automatic fill_random(input int density);
        for (int y = 0; y < VD; y++)
            for (int x = 0; x < HD; x++)
                img[y][x] = ($urandom_range(0, 99) < density);
    endtask

    task automatic fill_const(input bit val);
        for (int y = 0; y < VD; y++)
            for (int x = 0; x < HD; x++)
                img[y][x] = val;
    endtask

    initial begin
        int ones;
        int dil;
        bus.per_frame_vsync = 1'b0;
        bus.per_frame_href  = 1'b0;
        bus.per_frame_clken = 1'b0;
        bus.per_img_Bit     = 1'b0;
        rst = 1'b1;
        #1;
        checkOutput("reset_vsync", bus.post_frame_vsync, 1'b0);
        checkOutput("reset_href",  bus.post_frame_href,  1'b0);
        checkOutput("reset_clken", bus.post_frame_clken, 1'b0);
        checkOutput("reset_bit",   bus.post_img_Bit,     1'b0);
        for (int i = 0; i < 3; i++) drive_cycle(1'b0, 1'b0, 1'b0, 0, 0, 1'b0);
        rst = 1'b0;
        clear_hist();

        $display("[TB] random frames, dilate and erode");
        fill_random(40);
        applyStimulus(1'b1, -1, 1'b1, -1, 1'b1);
        check_frame("rand_dil", 1'b1, ones);
        fill_random(85);
        applyStimulus(1'b0, -1, 1'b0, -1, 1'b1);
        check_frame("rand_ero", 1'b0, ones);

        $display("[TB] single pixel at (3,2)");
        fill_const(1'b0);
        img[2][3] = 1'b1;
        applyStimulus(1'b1, -1, 1'b1, -1, 1'b1);
        check_frame("single_dil", 1'b1, ones);
        check_count("single_dil_ones", ones, 9);
        checkOutput("single_dil_corner", cap_img[4][5], 1'b1);
        applyStimulus(1'b0, -1, 1'b0, -1, 1'b1);
        check_frame("single_ero", 1'b0, ones);
        check_count("single_ero_ones", ones, 0);

        $display("[TB] all-ones erode, then all-zeros dilate");
        fill_const(1'b1);
        applyStimulus(1'b0, -1, 1'b0, -1, 1'b1);
        check_frame("ones_ero", 1'b0, ones);
`ifdef VIP_MORPH_BORDER_CLR_EN
        check_count("ones_ero_count", ones, 24);
`else
        check_count("ones_ero_count", ones, 48);
`endif
        fill_const(1'b0);
        applyStimulus(1'b1, -1, 1'b1, -1, 1'b1);
        check_frame("leak_dil", 1'b1, ones);
        check_count("leak_dil_ones", ones, 0);

        $display("[TB] mode change mid-frame");
        fill_random(60);
        applyStimulus(1'b1, 2, 1'b0, -1, 1'b1);
        check_frame("latch_dil", 1'b1, ones);
        fill_random(80);
        applyStimulus(1'b0, -1, 1'b0, -1, 1'b1);
        check_frame("latch_ero", 1'b0, ones);

        $display("[TB] reset during line 3");
        fill_random(50);
        applyStimulus(1'b1, -1, 1'b1, 3, 1'b0);
        fill_random(50);
        applyStimulus(1'b1, -1, 1'b1, -1, 1'b1);
        check_frame("post_rst_dil", 1'b1, ones);

        $display("[TB] random sweep");
        for (int f = 0; f < 4; f++) begin
            dil = $urandom_range(0, 1);
            fill_random(dil != 0 ? 25 : 85);
            applyStimulus(logic'(dil[0]), -1, logic'(dil[0]), -1, 1'b1);
            check_frame($sformatf("sweep%0d", f), dil[0], ones);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/vip_bin_morph_3x3.md
# vip_bin_morph_3x3

Streaming 3x3 binary morphology stage (erosion or dilation) placed directly downstream of the Sobel edge detector in the VIP chain. It consumes the 1-bit edge stream with its vsync/href/clken framing, buffers two previous lines, and emits a cleaned 1-bit stream with identical framing delayed by a fixed pipeline latency. It feeds the capture/display stage, which replicates the bit to 8-bit R/G/B.

## Interface
- IMG_HDISP, 640, active pixels per line (line buffer depth)
- IMG_VDISP, 480, active lines per frame
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-high reset
- per_frame_vsync  in  1  frame valid: low = sync, high = active frame
- per_frame_href  in  1  line valid
- per_frame_clken  in  1  pixel strobe; must equal per_frame_href (one pixel per clk, no gaps in a line)
- per_img_Bit  in  1  input binary pixel
- morph_mode  in  1  0 = erode (AND of window), 1 = dilate (OR of window)
- post_frame_vsync  out  1  per_frame_vsync delayed 3 clk
- post_frame_href  out  1  per_frame_href delayed 3 clk
- post_frame_clken  out  1  per_frame_clken delayed 3 clk
- post_img_Bit  out  1  morphology result

## Operation
- Counters: x_cnt counts clken pixels in the current line, cleared on href falling edge; y_cnt counts completed lines, incremented on href falling edge, cleared while per_frame_vsync low. Both saturate at IMG_HDISP / IMG_VDISP.
- Line buffers lb1, lb2 (IMG_HDISP x 1 bit): on clken with x_cnt < IMG_HDISP, read lb1[x], lb2[x], then write lb1[x] <= per_img_Bit, lb2[x] <= old lb1[x] (read-before-write).
- Window for input pixel (x,y): rows y-2..y, cols x-2..x. Output appears at the input position (x,y), so the result is spatially offset one pixel down-right from the window centre.
- Padding: taps with x-k < 0 or y-k < 0 take the neutral value (1 for erode, 0 for dilate). Line-buffer contents from a previous frame must never reach the output; masking uses y_cnt, not buffer reset.
- Pixels with x_cnt >= IMG_HDISP: no buffer write, post_img_Bit = 0.
- morph_mode is latched into mode_q every clk while per_frame_vsync is low; mode_q is held while vsync is high. A mid-frame change takes effect at the next frame.
- Line buffers are not reset. The design has no FSM; control is the counters plus the delay line.

## Timing
- Stage 1: register tap column {lb2[x], lb1[x], in} plus row/col mask bits.
- Stage 2: shift column into 3x3 window registers.
- Stage 3: masked AND/OR reduction registered to post_img_Bit.
- Latency: exactly 3 clk from per_img_Bit (clken high) to post_img_Bit (post_frame_clken high). vsync/href/clken use a 3-deep delay line that advances every clk.
- post_img_Bit is forced to 0 whenever the delayed clken is low.
- Reset values: all outputs 0, counters 0, window/delay registers 0, mode_q 0 (erode).
- rst asserted mid-frame: outputs drop to 0 immediately. After release, output is garbage-free: y_cnt = 0 masks stale buffer rows. Normal output resumes from the next rows processed.
- Simultaneous href fall and vsync fall: y_cnt clears, because clear has priority over increment.

## Configuration
- VIP_MORPH_BORDER_CLR_EN defined: post_img_Bit is forced to 0 for input positions with x < 2 or y < 2 (incomplete windows), in both modes.
- Undefined: neutral padding as in Operation.

## Test plan
- Use IMG_HDISP=8, IMG_VDISP=6, with a generator using H_SYNC=H_BACK=H_FRONT=5, V_SYNC=1, V_FRONT=1.
- Reset: assert rst during line 3 -> all outputs 0 the same clk. Release -> next full frame output matches the golden model.
- Latency: check post_frame_href rise/fall and post_frame_vsync edges -> exactly 3 clk after the corresponding inputs, every line.
- Single 1 at (3,2), dilate -> outputs 1 exactly at x 3..5, y 2..4 (9 pixels), all others 0. Same image, erode -> all 0.
- All-ones frame, erode -> all 48 outputs 1 (macro off). With VIP_MORPH_BORDER_CLR_EN -> rows 0-1 and cols 0-1 are 0, the remaining 24 pixels are 1.
- Frame leakage: all-ones frame, then all-zeros frame, dilate -> every output of the second frame is 0.
- Mode latch: toggle morph_mode from 1 to 0 at line 2 of a frame -> that frame is fully dilated, the next frame is eroded.
